digit_scan_ctrl: RTL and testbench

//   Multiplexed display scan controller. It sits directly upstream of the hex-to-7-segment decoder.
//   - Holds a multi-digit hex value and time-multiplexes it one digit at a time.
//   - Drives the 4-bit nibble to the decoder, plus an active-low digit select and a blank flag.
//   - New values are double-buffered and take effect only at a frame boundary, so a frame never mixes old and new digits.

---
 rtl/disp_pkg.sv | 9 +
 rtl/scan_prescaler.sv | 16 +
 rtl/digit_scan_ctrl.sv | 62 ++++++
 tb/tb_digit_scan_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// disp_pkg: shared nibble type and digit extraction for the display blocks
package disp_pkg;
  localparam int NIBBLE_W = 4;
  localparam int MAX_DIGITS = 8;
  typedef logic [NIBBLE_W-1:0] nibble_t;
  function automatic nibble_t digit_of(input logic [NIBBLE_W*MAX_DIGITS-1:0] value, input int i);
    return value[NIBBLE_W*i +: NIBBLE_W];
  endfunction
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: free-running divider, tick on the last count of each DIV-cycle period
module scan_prescaler #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q;
  assign tick = cnt_q == W'(DIV - 1);
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= tick ? '0 : cnt_q + W'(1);
  end
endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: multiplexed hex display scanner with frame-aligned double buffering
module digit_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] value,
  input  logic                           blank_lz,
  output nibble_t                        nibble,
  output logic [NUM_DIGITS-1:0]          digit_en,
  output logic                           blank,
  output logic                           frame_done
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int VW = NIBBLE_W * NUM_DIGITS;
  logic tick, wrap, blank_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [VW-1:0] disp_q, disp_d, pend_q, pend_d;
  logic pend_v_q, pend_v_d;
  nibble_t nibble_q;
  logic [NUM_DIGITS-1:0] digit_en_q;
  logic blank_q, frame_done_q;
  scan_prescaler #(.DIV(SCAN_DIV)) u_pre (.clk(clk), .rst(rst), .tick(tick));
  // a load landing on the wrap edge bypasses the pending buffer
  always_comb begin
    wrap = tick && idx_q == IW'(NUM_DIGITS - 1);
    idx_d = wrap ? '0 : idx_q + IW'(tick);
    disp_d = wrap ? (load ? value : pend_v_q ? pend_q : disp_q) : disp_q;
    pend_d = load && !wrap ? value : pend_q;
    pend_v_d = wrap ? 1'b0 : load | pend_v_q;
    blank_d = blank_lz && idx_d != '0 && (disp_d >> (NIBBLE_W * idx_d)) == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      disp_q <= '0;
      pend_q <= '0;
      pend_v_q <= 1'b0;
      nibble_q <= '0;
      digit_en_q <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
      blank_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      disp_q <= disp_d;
      pend_q <= pend_d;
      pend_v_q <= pend_v_d;
      nibble_q <= digit_of(32'(disp_d), int'(idx_d));
      digit_en_q <= blank_d ? '1 : ~(NUM_DIGITS'(1) << idx_d);
      blank_q <= blank_d;
      frame_done_q <= wrap;
    end
  end
  assign nibble = nibble_q;
  assign digit_en = digit_en_q;
  assign blank = blank_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: directed scenarios plus random traffic against a cycle-count reference model
module tb_digit_scan_ctrl;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0, blank_lz = 1'b0;
  logic [15:0] value = '0;
  logic [3:0] nibble, digit_en;
  logic blank, frame_done;
  int n_vec = 0, n_bad = 0;
  int k = 0;
  logic [15:0] m_disp = '0, m_pend = '0;
  bit m_pv = 0, m_fd = 0;

  digit_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .blank_lz(blank_lz),
    .nibble(nibble), .digit_en(digit_en), .blank(blank), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t k=%0d: got %h expected %h", tag, $time, k, obs, exp);
    end
  endtask

  // k counts edges since reset: digit held 4 edges, frame is 16 edges
  task automatic cyc(input logic r, input logic ld, input logic [15:0] v, input logic bl);
    int idx;
    logic [3:0] e_nib, e_en;
    logic e_bl;
    rst = r; load = ld; value = v; blank_lz = bl;
    @(posedge clk);
    if (r) begin
      k = 0; m_disp = 0; m_pend = 0; m_pv = 0; m_fd = 0;
    end else begin
      k++;
      m_fd = (k % 16) == 0;
      if (m_fd) begin
        m_disp = ld ? v : (m_pv ? m_pend : m_disp);
        m_pv = 0;
      end else if (ld) begin
        m_pend = v;
        m_pv = 1;
      end
    end
    idx = (k / 4) % 4;
    e_nib = 4'((m_disp >> (4 * idx)) & 16'hF);
    e_bl = !r && bl && idx != 0 && 32'(m_disp) < (32'd1 << (4 * idx));
    e_en = e_bl ? 4'hF : ~(4'd1 << idx);
    #1;
    chk("nibble", 32'(nibble), 32'(e_nib));
    chk("digit_en", 32'(digit_en), 32'(e_en));
    chk("blank", 32'(blank), 32'(e_bl));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
  endtask

  task automatic idle(input int n, input logic bl);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0, bl);
  endtask

  // idle until the next edge to be applied is edge number ≡ ph (mod 16)
  task automatic to_phase(input int ph, input logic bl);
    for (int i = 0; i < 16 && ((k + 1) % 16) != ph; i++) cyc(1'b0, 1'b0, 16'h0, bl);
  endtask

  initial begin
    cyc(1'b1, 1'b0, 16'h0, 1'b0);
    chk("rst_digit_en", 32'(digit_en), 32'h0000000E);
    chk("rst_nibble", 32'(nibble), 32'h0);
    idle(40, 1'b0);
    cyc(1'b1, 1'b0, 16'h0, 1'b0);
    idle(5, 1'b0);
    cyc(1'b0, 1'b1, 16'h12AB, 1'b0);
    idle(40, 1'b0);
    to_phase(3, 1'b1);
    cyc(1'b0, 1'b1, 16'h0050, 1'b1);
    idle(36, 1'b1);
    to_phase(0, 1'b0);
    cyc(1'b0, 1'b1, 16'h00F0, 1'b0);
    idle(20, 1'b0);
    to_phase(2, 1'b0);
    cyc(1'b0, 1'b1, 16'h1111, 1'b0);
    idle(3, 1'b0);
    cyc(1'b0, 1'b1, 16'h2222, 1'b0);
    idle(36, 1'b0);
    to_phase(2, 1'b0);
    cyc(1'b0, 1'b1, 16'h3333, 1'b0);
    to_phase(10, 1'b0);
    cyc(1'b1, 1'b0, 16'h0, 1'b0);
    chk("rst_mid_en", 32'(digit_en), 32'h0000000E);
    idle(40, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      case ($urandom_range(0, 3))
        0: v &= 16'h00FF;
        1: v &= 16'h000F;
        default: ;
      endcase
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0, v, (i / 50) % 2 == 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
